sdram_host_arbiter: RTL
=======================

# sdram_host_arbiter

Two-port arbiter that shares the single host port of the SDRAM controller (`sdram_cntl`) between two requesters in `sdram_test`: port A, the SPI/host fill path (mostly writes), and port B, the scan-line read path.
- Round-robin arbitration; the grant is held until the controller signals `done`.
- Muxes address, data and strobes to the controller and routes `done` back to the granted requester only.
- A timeout watchdog releases a grant that never completes.

## Interface
Parameters:
- ADDR_W, 24, SDRAM host word address width
- DATA_W, 16, SDRAM data width
- TIMEOUT, 255, max cycles a grant may wait for `host_done_i` (1..65535)

Ports:
- master_clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- a_rd_i, a_wr_i  in  1 each  port A read / write request (level, held until a_done_o)
- a_addr_i  in  ADDR_W  port A address
- a_data_i  in  DATA_W  port A write data
- a_done_o  out  1  port A operation complete (1-cycle pulse)
- b_rd_i, b_wr_i, b_addr_i, b_data_i, b_done_o  same as port A, for port B
- rd_data_o  out  DATA_W  read data, passed straight from host_data_i to both ports
- host_rd_o, host_wr_o  out  1 each  strobes to the controller
- host_addr_o  out  ADDR_W  address to the controller
- host_data_o  out  DATA_W  write data to the controller
- host_data_i  in  DATA_W  read data from the controller
- host_done_i  in  1  controller completion pulse
- timeout_o  out  1  sticky; set on a watchdog release, cleared only by reset
- grant_o  out  2  current grant: 00 none, 01 A, 10 B

## Operation
- FSM states: IDLE, GNT_A, GNT_B.
- Requests:
  - A port is requesting when rd or wr is high.
  - If rd and wr are both high, the op is a write; rd is masked.
- IDLE:
  - Only port A requesting -> GNT_A. Only port B requesting -> GNT_B.
  - Both requesting -> the port indicated by the priority pointer `prio` (reset = A).
- Entering GNT_x:
  - `prio` flips to the other port.
  - The watchdog counter loads 0.
- GNT_x outputs:
  - host_rd_o/host_wr_o/host_addr_o/host_data_o are combinationally muxed from port x.
  - The other port's inputs are ignored.
  - x_done_o = host_done_i. The non-granted done is forced 0.
- GNT_x exit on host_done_i = 1 -> IDLE.
- Requester obligation: drop or change its request at the same edge where done is sampled. A request still high in IDLE counts as a new request.
- Watchdog:
  - The counter increments each cycle in GNT_x.
  - When it reaches TIMEOUT with no done: go to IDLE, set timeout_o, and pulse no done.
  - The timed-out port's request is masked until it drops its strobes.
- Granted requester drops its request before done (abort): IDLE next cycle. The controller op may still finish; a done arriving in IDLE is discarded.
- Reset values: state IDLE, prio A, counter 0, timeout_o 0, grant_o 00, all host_* strobes 0, host_addr_o/host_data_o 0, done outputs 0.
- Async reset mid-operation abandons the grant immediately. The controller is reset by the same rst_i.

## Timing
- Request-to-strobe latency:
  - The request is sampled high in IDLE at edge n.
  - GNT state is entered at edge n and host strobes are asserted from edge n onward.
  - Result: one cycle after the request.
- Done path: combinational, zero-cycle, host_done_i -> x_done_o.
- Back-to-back ops:
  - Minimum one IDLE cycle between grants, so a requester gets at most one op every (controller latency + 1) cycles.
  - With both ports saturating, grants strictly alternate A, B, A, B.
- rd_data_o is valid in the cycle host_done_i is high for a read (controller contract). No extra register.
- Watchdog fires on the TIMEOUT-th cycle in GNT; the state is IDLE one cycle later.
- Counter width: clog2(TIMEOUT+1). It saturates and never wraps.

## Structure
- Package `sdram_arb_pkg`:
  - state enum (IDLE, GNT_A, GNT_B)
  - grant encoding constants (GRANT_NONE, GRANT_A, GRANT_B)
  - default ADDR_W/DATA_W
- Single module. The per-port request decode (rd/wr priority, timeout mask) is one small sub-module `arb_port_req`, instantiated twice.

## Test plan
- Single A write: A wr, addr 0x000010, data 0xBEEF; controller model returns done 5 cycles after strobe -> host_wr_o high the cycle after request, host_addr_o 0x000010, a_done_o pulses once, b_done_o stays 0, grant_o 01 -> 00.
- Simultaneous requests out of reset: A rd and B rd both asserted at cycle 0 -> A granted first, then B after one IDLE cycle. With both held continuously for 6 ops: order A,B,A,B,A,B.
- Port B read data: B rd at 0x123456; model returns 0x5A5A with done -> rd_data_o = 0x5A5A when b_done_o = 1. Port A strobes toggling during the B grant are never seen on host_*.
- rd+wr both high on port A -> host_wr_o = 1, host_rd_o = 0.
- Watchdog with TIMEOUT=8: model never asserts done -> IDLE after 8 grant cycles, timeout_o = 1 and remains set, no done pulse. Port B request is granted next. Port A is not regranted until its strobes drop.
- Reset mid-grant: rst_i pulsed 3 cycles into GNT_B -> all outputs 0 immediately (asynchronous), grant_o 00, prio = A on release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM host-port arbiter.
// State encoding, grant encoding and default bus widths.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/arb_port_req.sv
// Per-port request decode: write wins over read, and a port that
// timed out stays masked until it lowers both strobes.
module arb_port_req (
    input  logic clk,
    input  logic rst,
    input  logic rd,
    input  logic wr,
    input  logic timed_out,
    output logic active,
    output logic req,
    output logic rd_op,
    output logic wr_op
);

    logic mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask <= 1'b0;
        else if (timed_out)
            mask <= 1'b1;
        else if (!active)
            mask <= 1'b0;
    end

    assign active = rd | wr;
    assign req    = active & ~mask;
    assign wr_op  = wr;
    assign rd_op  = rd & ~wr;

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the sdram_cntl host port between the
// fill path (A) and the scan-line read path (B), with a watchdog.
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              master_clk_i,
    input  logic              rst_i,
    input  logic              a_rd_i,
    input  logic              a_wr_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_done_o,
    input  logic              b_rd_i,
    input  logic              b_wr_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_done_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              host_rd_o,
    output logic              host_wr_o,
    output logic [ADDR_W-1:0] host_addr_o,
    output logic [DATA_W-1:0] host_data_o,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              host_done_i,
    output logic              timeout_o,
    output logic [1:0]        grant_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAXC = CW'(TIMEOUT);

    state_t        state, nxt;
    logic          prio, prio_nxt;
    logic [CW-1:0] cnt;
    logic          fire, to_a, to_b;
    logic          a_act, a_req, a_rd, a_wr;
    logic          b_act, b_req, b_rd, b_wr;

    arb_port_req u_req_a (
        .clk       (master_clk_i),
        .rst       (rst_i),
        .rd        (a_rd_i),
        .wr        (a_wr_i),
        .timed_out (to_a),
        .active    (a_act),
        .req       (a_req),
        .rd_op     (a_rd),
        .wr_op     (a_wr)
    );

    arb_port_req u_req_b (
        .clk       (master_clk_i),
        .rst       (rst_i),
        .rd        (b_rd_i),
        .wr        (b_wr_i),
        .timed_out (to_b),
        .active    (b_act),
        .req       (b_req),
        .rd_op     (b_rd),
        .wr_op     (b_wr)
    );

    // prio: 0 = A wins a tie, 1 = B wins a tie
    always_ff @(posedge master_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= nxt;
            prio      <= prio_nxt;
            timeout_o <= timeout_o | fire;
            if (state == IDLE)
                cnt <= '0;
            else if (cnt != MAXC)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nxt         = state;
        prio_nxt    = prio;
        fire        = 1'b0;
        to_a        = 1'b0;
        to_b        = 1'b0;
        grant_o     = GRANT_NONE;
        host_rd_o   = 1'b0;
        host_wr_o   = 1'b0;
        host_addr_o = '0;
        host_data_o = '0;
        a_done_o    = 1'b0;
        b_done_o    = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_req && (!b_req || !prio)) begin
                    nxt      = GNT_A;
                    prio_nxt = 1'b1;
                end else if (b_req) begin
                    nxt      = GNT_B;
                    prio_nxt = 1'b0;
                end
            end
            GNT_A: begin
                grant_o     = GRANT_A;
                host_rd_o   = a_rd;
                host_wr_o   = a_wr;
                host_addr_o = a_addr_i;
                host_data_o = a_data_i;
                a_done_o    = host_done_i;
                if (host_done_i || !a_act) begin
                    nxt = IDLE;
                end else if (cnt == LAST) begin
                    nxt  = IDLE;
                    fire = 1'b1;
                    to_a = 1'b1;
                end
            end
            GNT_B: begin
                grant_o     = GRANT_B;
                host_rd_o   = b_rd;
                host_wr_o   = b_wr;
                host_addr_o = b_addr_i;
                host_data_o = b_data_i;
                b_done_o    = host_done_i;
                if (host_done_i || !b_act) begin
                    nxt = IDLE;
                end else if (cnt == LAST) begin
                    nxt  = IDLE;
                    fire = 1'b1;
                    to_b = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign rd_data_o = host_data_i;

endmodule
